game_flow_ctrl: RTL and testbench

//  Downstream of the start-screen FSM: consumes its game_state flag plus player/keyboard events.

---
 rtl/game_flow_pkg.sv | 21 ++
 rtl/game_flow_ctrl_frame_timer.sv | 36 +++
 rtl/game_flow_ctrl.sv | 174 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_pkg.sv
// Shared types and widths for the game round-flow controller.
// GAME_FLOW_PAUSE_EN adds the PAUSED encoding.
package game_flow_pkg;

   localparam int LIVES_W = 3;
   localparam int LEVEL_W = 4;
   localparam int TIMER_W = 8;

   typedef enum logic [2:0] {
      TITLE  = 3'd0,
      READY  = 3'd1,
      PLAY   = 3'd2,
      DYING  = 3'd3,
      CLEAR  = 3'd4,
      OVER   = 3'd5
`ifdef GAME_FLOW_PAUSE_EN
      , PAUSED = 3'd6
`endif
   } flow_mode_t;

endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// Loadable frame-tick down-counter; done is asserted while the count sits at zero.
module frame_timer
   import game_flow_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               frame_tick,
   output logic               done
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   // A load on state entry always overrides a coincident frame tick.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (frame_tick && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Round-flow FSM: title -> ready -> play -> die/clear -> game-over, with lives/level counters.
// GAME_FLOW_PAUSE_EN adds the pause_key port and the PAUSED state.
module game_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter int unsigned INIT_LIVES   = 3,
   parameter int unsigned MAX_LEVEL    = 15,
   parameter int unsigned READY_FRAMES = 120,
   parameter int unsigned DIE_FRAMES   = 90,
   parameter int unsigned CLEAR_FRAMES = 90,
   parameter int unsigned OVER_FRAMES  = 180
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               game_state,
   input  logic               start_key,
   input  logic               player_hit,
   input  logic               enemies_clear,
`ifdef GAME_FLOW_PAUSE_EN
   input  logic               pause_key,
`endif
   output flow_mode_t         mode,
   output logic [LIVES_W-1:0] lives,
   output logic [LEVEL_W-1:0] level,
   output logic               freeze,
   output logic               respawn
);

   localparam logic [LIVES_W-1:0] INIT_LIVES_V = LIVES_W'(INIT_LIVES);
   localparam logic [LEVEL_W-1:0] MAX_LEVEL_V  = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] FIRST_LEVEL  = LEVEL_W'(1);
   localparam logic [TIMER_W-1:0] READY_V      = TIMER_W'(READY_FRAMES);
   localparam logic [TIMER_W-1:0] DIE_V        = TIMER_W'(DIE_FRAMES);
   localparam logic [TIMER_W-1:0] CLEAR_V      = TIMER_W'(CLEAR_FRAMES);
   localparam logic [TIMER_W-1:0] OVER_V       = TIMER_W'(OVER_FRAMES);

   flow_mode_t         mode_q, mode_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               respawn_q, respawn_d;
   logic               start_prev_q, start_prev_d;
   logic               start_rise;
   logic               timer_load;
   logic [TIMER_W-1:0] timer_val;
   logic               timer_done;
`ifdef GAME_FLOW_PAUSE_EN
   logic               pause_prev_q, pause_prev_d;
   logic               pause_rise;
`endif

   frame_timer u_timer (
      .Clk        (Clk),
      .Reset      (Reset),
      .load       (timer_load),
      .load_val   (timer_val),
      .frame_tick (frame_tick),
      .done       (timer_done)
   );

   // Edge regs track the keys in every state, so a key held across a transition never re-fires.
   assign start_prev_d = start_key;
   assign start_rise   = start_key & ~start_prev_q;
`ifdef GAME_FLOW_PAUSE_EN
   assign pause_prev_d = pause_key;
   assign pause_rise   = pause_key & ~pause_prev_q;
`endif

   always_comb begin
      mode_d     = mode_q;
      lives_d    = lives_q;
      level_d    = level_q;
      respawn_d  = 1'b0;
      timer_load = 1'b0;
      timer_val  = '0;
      case (mode_q)
         TITLE: begin
            if (!game_state && start_rise) begin
               mode_d     = READY;
               lives_d    = INIT_LIVES_V;
               level_d    = FIRST_LEVEL;
               timer_load = 1'b1;
               timer_val  = READY_V;
            end
         end
         READY: begin
            if (timer_done) begin
               mode_d    = PLAY;
               respawn_d = 1'b1;
            end
         end
         PLAY: begin
            if (player_hit) begin
               mode_d     = DYING;
               timer_load = 1'b1;
               timer_val  = DIE_V;
            end else if (enemies_clear) begin
               mode_d     = CLEAR;
               timer_load = 1'b1;
               timer_val  = CLEAR_V;
            end
`ifdef GAME_FLOW_PAUSE_EN
            else if (pause_rise) begin
               mode_d = PAUSED;
            end
`endif
         end
         DYING: begin
            if (timer_done) begin
               timer_load = 1'b1;
               if (lives_q <= LIVES_W'(1)) begin
                  mode_d    = OVER;
                  lives_d   = '0;
                  timer_val = OVER_V;
               end else begin
                  mode_d    = READY;
                  lives_d   = lives_q - 1'b1;
                  timer_val = READY_V;
               end
            end
         end
         CLEAR: begin
            if (timer_done) begin
               mode_d     = READY;
               level_d    = (level_q >= MAX_LEVEL_V) ? MAX_LEVEL_V : level_q + 1'b1;
               timer_load = 1'b1;
               timer_val  = READY_V;
            end
         end
         OVER: begin
            if (timer_done) begin
               mode_d = TITLE;
            end
         end
`ifdef GAME_FLOW_PAUSE_EN
         PAUSED: begin
            if (pause_rise) begin
               mode_d = PLAY;
            end
         end
`endif
         default: mode_d = TITLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mode_q       <= TITLE;
         lives_q      <= INIT_LIVES_V;
         level_q      <= FIRST_LEVEL;
         respawn_q    <= 1'b0;
         start_prev_q <= 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
         pause_prev_q <= 1'b0;
`endif
      end else begin
         mode_q       <= mode_d;
         lives_q      <= lives_d;
         level_q      <= level_d;
         respawn_q    <= respawn_d;
         start_prev_q <= start_prev_d;
`ifdef GAME_FLOW_PAUSE_EN
         pause_prev_q <= pause_prev_d;
`endif
      end
   end

   assign mode    = mode_q;
   assign lives   = lives_q;
   assign level   = level_q;
   assign freeze  = (mode_q != PLAY);
   assign respawn = respawn_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl (pause steps only with GAME_FLOW_PAUSE_EN).
module tb_game_flow_ctrl;
   import game_flow_pkg::*;

   logic               Clk;
   logic               Reset;
   logic               frame_tick;
   logic               game_state;
   logic               start_key;
   logic               player_hit;
   logic               enemies_clear;
`ifdef GAME_FLOW_PAUSE_EN
   logic               pause_key;
`endif
   flow_mode_t         mode;
   logic [LIVES_W-1:0] lives;
   logic [LEVEL_W-1:0] level;
   logic               freeze;
   logic               respawn;

   int checks = 0;
   int errors = 0;

   game_flow_ctrl dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_tick    (frame_tick),
      .game_state    (game_state),
      .start_key     (start_key),
      .player_hit    (player_hit),
      .enemies_clear (enemies_clear),
`ifdef GAME_FLOW_PAUSE_EN
      .pause_key     (pause_key),
`endif
      .mode          (mode),
      .lives         (lives),
      .level         (level),
      .freeze        (freeze),
      .respawn       (respawn)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic frames(input int n);
      frame_tick = 1'b1;
      repeat (n) step();
      frame_tick = 1'b0;
   endtask

   // From READY entry: 120 ticks, then one more cycle lands in PLAY.
   task automatic goto_play();
      frames(120);
      step();
   endtask

   // From PLAY: clear, 90-frame banner, back through READY into PLAY.
   task automatic clear_round();
      enemies_clear = 1'b1;
      step();
      enemies_clear = 1'b0;
      frames(90);
      step();
      goto_play();
   endtask

   // From PLAY: hit, 90-frame death, into READY (or OVER on the last life).
   task automatic die_round();
      player_hit = 1'b1;
      step();
      player_hit = 1'b0;
      frames(90);
      step();
   endtask

   initial begin
      Reset         = 1'b1;
      frame_tick    = 1'b0;
      game_state    = 1'b1;
      start_key     = 1'b0;
      player_hit    = 1'b0;
      enemies_clear = 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
      pause_key     = 1'b0;
`endif
      step();
      step();
      Reset = 1'b0;
      step();

      chk("rst_mode", int'(mode), int'(TITLE));
      chk("rst_lives", int'(lives), 3);
      chk("rst_level", int'(level), 1);
      chk("rst_freeze", int'(freeze), 1);
      chk("rst_respawn", int'(respawn), 0);

      // Start key ignored while the start screen is still up
      repeat (3) begin
         start_key = 1'b1;
         step();
         start_key = 1'b0;
         step();
      end
      chk("title_hold_mode", int'(mode), int'(TITLE));

      game_state = 1'b0;
      start_key  = 1'b1;
      step();
      start_key  = 1'b0;
      chk("start_mode", int'(mode), int'(READY));
      chk("start_freeze", int'(freeze), 1);

      frames(120);
      chk("ready_dwell_mode", int'(mode), int'(READY));
      chk("ready_dwell_respawn", int'(respawn), 0);
      step();
      chk("play_mode", int'(mode), int'(PLAY));
      chk("play_respawn", int'(respawn), 1);
      chk("play_freeze", int'(freeze), 0);
      step();
      chk("play_respawn_drop", int'(respawn), 0);
      chk("play_stay", int'(mode), int'(PLAY));

      // Hit and clear together: hit wins
      player_hit    = 1'b1;
      enemies_clear = 1'b1;
      step();
      player_hit    = 1'b0;
      enemies_clear = 1'b0;
      chk("hit_wins_mode", int'(mode), int'(DYING));
      frames(90);
      chk("die_dwell_mode", int'(mode), int'(DYING));
      step();
      chk("die_ready_mode", int'(mode), int'(READY));
      chk("die_lives", int'(lives), 2);
      chk("die_level", int'(level), 1);

      // Events outside PLAY are ignored
      player_hit    = 1'b1;
      enemies_clear = 1'b1;
      step();
      player_hit    = 1'b0;
      enemies_clear = 1'b0;
      chk("ready_ignore_mode", int'(mode), int'(READY));
      chk("ready_ignore_lives", int'(lives), 2);
      goto_play();
      chk("ready_ignore_play", int'(mode), int'(PLAY));

      repeat (3) clear_round();
      chk("lvl4_level", int'(level), 4);
      chk("lvl4_mode", int'(mode), int'(PLAY));
      enemies_clear = 1'b1;
      step();
      enemies_clear = 1'b0;
      chk("clear_mode", int'(mode), int'(CLEAR));
      frames(90);
      step();
      chk("clear_ready_mode", int'(mode), int'(READY));
      chk("clear_level5", int'(level), 5);
      goto_play();
      repeat (10) clear_round();
      chk("lvl15_level", int'(level), 15);
      enemies_clear = 1'b1;
      step();
      enemies_clear = 1'b0;
      frames(90);
      step();
      chk("sat_mode", int'(mode), int'(READY));
      chk("sat_level", int'(level), 15);
      goto_play();

      // Lose one more life to reach lives=1 in PLAY, then async reset
      die_round();
      goto_play();
      chk("pre_rst_lives", int'(lives), 1);
      chk("pre_rst_mode", int'(mode), int'(PLAY));
      Reset = 1'b1;
      #1;
      chk("async_rst_mode", int'(mode), int'(TITLE));
      chk("async_rst_lives", int'(lives), 3);
      chk("async_rst_level", int'(level), 1);
      chk("async_rst_freeze", int'(freeze), 1);
      step();
      Reset = 1'b0;
      step();

      // Full game over from three lives
      start_key = 1'b1;
      step();
      start_key = 1'b0;
      chk("restart_mode", int'(mode), int'(READY));
      goto_play();
      die_round();
      chk("go_lives2", int'(lives), 2);
      goto_play();
      die_round();
      chk("go_lives1", int'(lives), 1);
      goto_play();
      start_key  = 1'b1;
      player_hit = 1'b1;
      step();
      player_hit = 1'b0;
      frames(90);
      step();
      chk("over_mode", int'(mode), int'(OVER));
      chk("over_lives", int'(lives), 0);
      frames(180);
      chk("over_dwell_mode", int'(mode), int'(OVER));
      step();
      chk("over_title_mode", int'(mode), int'(TITLE));
      step();
      step();
      chk("held_key_no_restart", int'(mode), int'(TITLE));
      chk("title_lives_hold", int'(lives), 0);
      start_key = 1'b0;
      step();
      chk("released_title", int'(mode), int'(TITLE));
      start_key = 1'b1;
      step();
      start_key = 1'b0;
      chk("repress_mode", int'(mode), int'(READY));
      chk("repress_lives", int'(lives), 3);
      chk("repress_level", int'(level), 1);

`ifdef GAME_FLOW_PAUSE_EN
      goto_play();
      pause_key = 1'b1;
      step();
      pause_key = 1'b0;
      chk("pause_mode", int'(mode), int'(PAUSED));
      chk("pause_freeze", int'(freeze), 1);
      player_hit = 1'b1;
      step();
      player_hit = 1'b0;
      step();
      chk("pause_ignore_mode", int'(mode), int'(PAUSED));
      chk("pause_ignore_lives", int'(lives), 3);
      pause_key = 1'b1;
      step();
      pause_key = 1'b0;
      chk("unpause_mode", int'(mode), int'(PLAY));
      chk("unpause_respawn", int'(respawn), 0);
      chk("unpause_freeze", int'(freeze), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
